shutdown_sense_scan: RTL

Scans the eight per-board hardware shutdown-latch sense lines through a shared external 8:1 analog/digital mux: one select bus out, one sense bit in. Debounces each board's reading across successive scan frames. On a confirmed shutdown, latches the board number. Sits directly upstream of the hardware manager and drives its shutdown_sense and sense_num inputs; en is driven from the manager's n_shutdown_rst.

---
 rtl/shutdown_sense_scan_if.sv | 31 +++
 rtl/shutdown_sense_scan.sv | 135 +++++++++++++
 2 files changed

// File: rtl/shutdown_sense_scan_if.sv
// Shutdown-sense scanner bus: mux select/sense pair plus manager-facing outputs.
// Carries sense_mask only when SHUTDOWN_SENSE_MASK_EN is defined.
interface shutdown_sense_scan_if;
    logic       en;
    logic       sense_in;
    logic [2:0] sense_sel;
    logic       shutdown_sense;
    logic [2:0] sense_num;
    logic [7:0] sense_status;
`ifdef SHUTDOWN_SENSE_MASK_EN
    logic [7:0] sense_mask;

    modport master (
        output en, sense_in, sense_mask,
        input  sense_sel, shutdown_sense, sense_num, sense_status
    );
    modport slave (
        input  en, sense_in, sense_mask,
        output sense_sel, shutdown_sense, sense_num, sense_status
    );
`else
    modport master (
        output en, sense_in,
        input  sense_sel, shutdown_sense, sense_num, sense_status
    );
    modport slave (
        input  en, sense_in,
        output sense_sel, shutdown_sense, sense_num, sense_status
    );
`endif
endinterface

// File: rtl/shutdown_sense_scan.sv
// Scans 8 board shutdown latches via an external 8:1 mux, debounces per frame.
// Optional SHUTDOWN_SENSE_MASK_EN adds a per-board ignore mask.
module shutdown_sense_scan #(
    parameter int SETTLE_CYCLES  = 25,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shutdown_sense_scan_if.slave  bus
);
    localparam int CW = ($clog2(DEBOUNCE_COUNT + 1) < 1)
                      ? 1 : $clog2(DEBOUNCE_COUNT + 1);
    localparam int SW = ($clog2(SETTLE_CYCLES) < 1)
                      ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        LATCHED
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [2:0]      sel_q, sel_d;
    logic            det_q, det_d;
    logic [2:0]      num_q, num_d;
    logic [7:0]      status_q, status_d;
    logic [CW-1:0]   cnt_q [8];
    logic [CW-1:0]   cnt_d [8];
    logic            sync1_q, sync2_q;

    logic            hit;
    logic            confirm;
    logic [CW-1:0]   cnt_cur;
    logic [CW-1:0]   cnt_inc;

    // Two-flop synchronizer; en low clears it like every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else if (!bus.en) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.sense_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SHUTDOWN_SENSE_MASK_EN
    assign hit = sync2_q & ~bus.sense_mask[sel_q];
`else
    assign hit = sync2_q;
`endif

    assign cnt_cur = cnt_q[sel_q];
    assign cnt_inc = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + 1'b1;
    assign confirm = hit && ((int'(cnt_cur) + 1) == DEBOUNCE_COUNT);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        det_d    = det_q;
        num_d    = num_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        if (!bus.en) begin
            state_d  = IDLE;
            settle_d = '0;
            sel_d    = '0;
            det_d    = 1'b0;
            num_d    = '0;
            status_d = '0;
            for (int i = 0; i < 8; i++) cnt_d[i] = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    sel_d    = '0;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_d = SAMPLE;
                    else settle_d = settle_q + 1'b1;
                end
                SAMPLE: begin
                    status_d[sel_q] = hit;
                    cnt_d[sel_q]    = hit ? cnt_inc : '0;
                    if (confirm) begin
                        state_d = LATCHED;
                        det_d   = 1'b1;
                        num_d   = sel_q;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = '0;
                        sel_d    = sel_q + 3'd1;
                    end
                end
                LATCHED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            sel_q    <= '0;
            det_q    <= 1'b0;
            num_q    <= '0;
            status_q <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            det_q    <= det_d;
            num_q    <= num_d;
            status_q <= status_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.sense_sel      = sel_q;
    assign bus.shutdown_sense = det_q;
    assign bus.sense_num      = num_q;
    assign bus.sense_status   = status_q;

endmodule
